// File: rtl/gfx_pkg.sv
// Shared graphics types and defaults for the pixel back end.
// Provides RGB565/depth typedefs, default screen size, the far-depth
// constant, the zbuffer_writer state type and a saturating counter helper.
package gfx_pkg;

  localparam int unsigned H_RES_DEF       = 320;
  localparam int unsigned V_RES_DEF       = 180;
  localparam int unsigned DEPTH_WIDTH_DEF = 16;

  typedef logic [15:0]                  rgb565_t;
  typedef logic [DEPTH_WIDTH_DEF-1:0]   depth_t;

  // Farthest representable depth; a cleared depth buffer holds this everywhere.
  localparam depth_t DEPTH_FAR = '1;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_COMPARE,
    ST_WRITE
  } zb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth buffer: one synchronous write port and one read
// port with a two-stage registered read (data valid two cycles after the
// address is presented). Contents are undefined until the first clear sweep.
// Ports:
//   clk_in              clock
//   rd_addr / rd_data   read address, read data (2-cycle latency)
//   we / wr_addr / wr_data  write strobe, address, data
module depth_ram #(
  parameter int unsigned DEPTH = 57600,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 16
) (
  input  logic             clk_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Write port plus two read register stages (array + output register).
  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q    <= mem[rd_addr];
    rd_data <= rd_q;
  end

endmodule

// File: rtl/zbuffer_writer.sv
// Depth-tested pixel writer with frame clear.
// Accepts shaded pixels over valid/ready, reads the stored depth, and on a
// strictly-closer depth writes colour to the frame buffer and depth to the
// internal depth RAM. A clear sweep resets every depth to far and every
// colour to CLEAR_COLOR; it runs after reset and on request.
// Ports:
//   clk_in, rst_in                   clock, synchronous active-high reset
//   valid_in, ready_out              pixel handshake (ready is a state decode)
//   color_in, hcount_in, vcount_in, depth_in   pixel payload
//   short_circuit_in                 culled-triangle pulse (statistics only)
//   clear_in                         frame clear request pulse
//   fb_addr_out, fb_data_out, fb_we_out  frame-buffer write port
//   clear_done_out                   pulse on the final clear write
//   pix_written_out, pix_rejected_out, pix_culled_out  saturating counters
module zbuffer_writer
  import gfx_pkg::*;
#(
  parameter int unsigned  H_RES       = H_RES_DEF,
  parameter int unsigned  V_RES       = V_RES_DEF,
  parameter int unsigned  DEPTH_WIDTH = DEPTH_WIDTH_DEF,
  parameter rgb565_t      CLEAR_COLOR = 16'h0000,
  localparam int unsigned ADDR_WIDTH  = $clog2(H_RES * V_RES),
  localparam int unsigned H_WIDTH     = $clog2(H_RES),
  localparam int unsigned V_WIDTH     = $clog2(V_RES)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [15:0]            color_in,
  input  logic [H_WIDTH-1:0]     hcount_in,
  input  logic [V_WIDTH-1:0]     vcount_in,
  input  logic [DEPTH_WIDTH-1:0] depth_in,
  input  logic                   short_circuit_in,
  input  logic                   clear_in,
  output logic [ADDR_WIDTH-1:0]  fb_addr_out,
  output logic [15:0]            fb_data_out,
  output logic                   fb_we_out,
  output logic                   clear_done_out,
  output logic [31:0]            pix_written_out,
  output logic [31:0]            pix_rejected_out,
  output logic [31:0]            pix_culled_out
);

  localparam int unsigned         NUM_PIX   = H_RES * V_RES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
  localparam logic [H_WIDTH-1:0]  H_MAX     = H_WIDTH'(H_RES - 1);
  localparam logic [V_WIDTH-1:0]  V_MAX     = V_WIDTH'(V_RES - 1);

  zb_state_t               state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [ADDR_WIDTH-1:0]   pix_addr;
  rgb565_t                 pix_color;
  logic [DEPTH_WIDTH-1:0]  pix_depth;
  logic                    pix_oor;
  logic                    rd_phase;
  logic                    clear_pending;

  logic                    oor_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic                    ram_we_c;
  logic [ADDR_WIDTH-1:0]   ram_waddr_c;
  logic [DEPTH_WIDTH-1:0]  ram_wdata_c;
  logic [DEPTH_WIDTH-1:0]  ram_rdata;

  // Acceptance-time address and range check; H_RES is constant so the
  // multiply reduces to shifts and adds.
  assign oor_c  = (hcount_in > H_MAX) || (vcount_in > V_MAX);
  assign addr_c = ADDR_WIDTH'(vcount_in) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(hcount_in);

  assign ready_out = (state == ST_IDLE) && !clear_pending;

  // Depth RAM write source: clear sweep (far depth) or a passing pixel.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_waddr_c = pix_addr;
    ram_wdata_c = pix_depth;
    if (state == ST_CLEAR) begin
      ram_we_c    = !clear_done_out;
      ram_waddr_c = sweep_addr;
      ram_wdata_c = '1;
    end else if (state == ST_WRITE) begin
      ram_we_c = 1'b1;
    end
  end

  depth_ram #(
    .DEPTH (NUM_PIX),
    .WIDTH (DEPTH_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_depth_ram (
    .clk_in  (clk_in),
    .rd_addr (pix_addr),
    .rd_data (ram_rdata),
    .we      (ram_we_c),
    .wr_addr (ram_waddr_c),
    .wr_data (ram_wdata_c)
  );

  // Control FSM with registered frame-buffer port and counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_CLEAR;
      sweep_addr       <= '0;
      pix_addr         <= '0;
      pix_color        <= '0;
      pix_depth        <= '0;
      pix_oor          <= 1'b0;
      rd_phase         <= 1'b0;
      clear_pending    <= 1'b0;
      fb_addr_out      <= '0;
      fb_data_out      <= '0;
      fb_we_out        <= 1'b0;
      clear_done_out   <= 1'b0;
      pix_written_out  <= '0;
      pix_rejected_out <= '0;
      pix_culled_out   <= '0;
    end else begin
      fb_we_out      <= 1'b0;
      clear_done_out <= 1'b0;

      if (short_circuit_in && (state != ST_CLEAR)) begin
        pix_culled_out <= sat_inc(pix_culled_out);
      end
      if (clear_in && (state != ST_CLEAR)) begin
        clear_pending <= 1'b1;
      end

      case (state)
        // One write per cycle; the cycle after the last write (flagged by
        // clear_done_out) hands over to IDLE so ready rises one cycle later.
        ST_CLEAR: begin
          if (clear_done_out) begin
            state <= ST_IDLE;
          end else begin
            fb_we_out   <= 1'b1;
            fb_addr_out <= sweep_addr;
            fb_data_out <= CLEAR_COLOR;
            sweep_addr  <= sweep_addr + ADDR_WIDTH'(1);
            if (sweep_addr == LAST_ADDR) begin
              clear_done_out <= 1'b1;
            end
          end
        end

        ST_IDLE: begin
          if (clear_pending) begin
            state            <= ST_CLEAR;
            sweep_addr       <= '0;
            clear_pending    <= 1'b0;
            pix_written_out  <= '0;
            pix_rejected_out <= '0;
            pix_culled_out   <= '0;
          end else if (valid_in) begin
            pix_addr  <= addr_c;
            pix_color <= color_in;
            pix_depth <= depth_in;
            pix_oor   <= oor_c;
            rd_phase  <= 1'b0;
            state     <= ST_READ;
          end
        end

        // Hold the read address for the RAM's two-cycle latency; an
        // out-of-range pixel is dropped here without touching memory.
        ST_READ: begin
          if (pix_oor) begin
            pix_rejected_out <= sat_inc(pix_rejected_out);
            state            <= ST_IDLE;
          end else if (rd_phase) begin
            state <= ST_COMPARE;
          end else begin
            rd_phase <= 1'b1;
          end
        end

        // Strictly closer wins; equal depth is rejected.
        ST_COMPARE: begin
          if (pix_depth < ram_rdata) begin
            fb_we_out   <= 1'b1;
            fb_addr_out <= pix_addr;
            fb_data_out <= pix_color;
            state       <= ST_WRITE;
          end else begin
            pix_rejected_out <= sat_inc(pix_rejected_out);
            state            <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          pix_written_out <= sat_inc(pix_written_out);
          state           <= ST_IDLE;
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
